// File: rtl/integer_divider_pkg.sv
// Shared widths, state encoding and helpers for the iterative integer divider.
package integer_divider_pkg;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned DIV_COUNT_WIDTH = $clog2(DATA_WIDTH);
  localparam int unsigned DIV_STATE_WIDTH = 2;

  typedef enum logic [DIV_STATE_WIDTH-1:0] {
    StIdle  = 2'd0,
    StCalc  = 2'd1,
    StFixup = 2'd2,
    StDone  = 2'd3
  } div_state_e;

  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam word_t MostNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic word_t cond_negate(input logic neg, input word_t v);
    return neg ? word_t'(-v) : v;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift/compare/subtract iteration on a (Width+1)-bit partial remainder.
module divider_step
  import integer_divider_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH
) (
  input  logic [Width:0]   rem_i,
  input  logic             dividend_bit_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width:0]   rem_o,
  output logic             quot_bit_o
);

  logic [Width+1:0] shifted;
  logic [Width+1:0] diff;

  always_comb begin
    shifted    = {rem_i, dividend_bit_i};
    diff       = shifted - {2'b00, divisor_i};
    // Non-negative difference means the divisor fits: keep it and emit a 1.
    quot_bit_o = ~diff[Width+1];
    rem_o      = quot_bit_o ? diff[Width:0] : shifted[Width:0];
  end

endmodule

// File: rtl/integer_divider.sv
// Iterative signed/unsigned divider (div/divu/rem/remu), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow at accept.
module integer_divider
  import integer_divider_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  unsignedSelect,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  busy,
  output logic                  done
);

  div_state_e                 state_q, state_d;
  logic [DIV_COUNT_WIDTH-1:0] count_q;
  logic [DATA_WIDTH:0]        prem_q;
  word_t                      acc_q;
  word_t                      dvsr_q;
  logic                       q_neg_q, r_neg_q, dbz_q;
  word_t                      quot_q, rem_q;

  logic                       accept;
  logic                       a_neg, b_neg;
  word_t                      a_mag, b_mag;
  logic [DATA_WIDTH:0]        step_rem;
  logic                       step_qbit;
  logic                       early_out;
  word_t                      early_q, early_r;

`ifdef DIV_EARLY_OUT_EN
  logic dbz_in, ovf_in;
  always_comb begin
    dbz_in    = (divisor == '0);
    ovf_in    = !unsignedSelect && (dividend == MostNeg) && (divisor == '1);
    early_out = dbz_in | ovf_in;
    early_q   = dbz_in ? '1 : MostNeg;
    early_r   = dbz_in ? dividend : '0;
  end
`else
  always_comb begin
    early_out = 1'b0;
    early_q   = '0;
    early_r   = '0;
  end
`endif

  always_comb begin
    accept = start & ~busy;
    a_neg  = !unsignedSelect && dividend[DATA_WIDTH-1];
    b_neg  = !unsignedSelect && divisor[DATA_WIDTH-1];
    a_mag  = cond_negate(a_neg, dividend);
    b_mag  = cond_negate(b_neg, divisor);
  end

  divider_step #(
    .Width(DATA_WIDTH)
  ) u_step (
    .rem_i         (prem_q),
    .dividend_bit_i(acc_q[DATA_WIDTH-1]),
    .divisor_i     (dvsr_q),
    .rem_o         (step_rem),
    .quot_bit_o    (step_qbit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = early_out ? StDone : StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc:  if (count_q == '0) state_d = StFixup;
      StFixup: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StCalc) || (state_q == StFixup);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      prem_q  <= '0;
      acc_q   <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (accept) begin
      count_q <= DIV_COUNT_WIDTH'(DATA_WIDTH - 1);
      prem_q  <= '0;
      acc_q   <= a_mag;
      dvsr_q  <= b_mag;
      q_neg_q <= a_neg ^ b_neg;
      r_neg_q <= a_neg;
      dbz_q   <= (divisor == '0);
      if (early_out) begin
        quot_q <= early_q;
        rem_q  <= early_r;
      end
    end else if (state_q == StCalc) begin
      prem_q <= step_rem;
      acc_q  <= {acc_q[DATA_WIDTH-2:0], step_qbit};
      if (count_q != '0) count_q <= count_q - 1'b1;
    end else if (state_q == StFixup) begin
      // All-ones quotient from a zero divisor is architectural; never negate it.
      quot_q <= cond_negate(q_neg_q && !dbz_q, acc_q);
      rem_q  <= cond_negate(r_neg_q, prem_q[DATA_WIDTH-1:0]);
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_integer_divider.sv
// Randomized self-checking bench for integer_divider against an arithmetic reference model.
module tb_integer_divider;
  import integer_divider_pkg::*;

  localparam int unsigned W = DATA_WIDTH;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         unsignedSelect = 1'b0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] last_q = '0;

  integer_divider dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .dividend      (dividend),
    .divisor       (divisor),
    .unsignedSelect(unsignedSelect),
    .quotient      (quotient),
    .remainder     (remainder),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic uns);
    return (b == '0) || (!uns && a == MostNeg && b == '1);
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (uns) begin
      q = a / b;
      r = a % b;
    end else if (a == MostNeg && b == '1) begin
      q = MostNeg;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endtask

  // Called at a negedge while idle or in the done cycle; returns at the negedge where done is high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                        input string tag, input int ign_at);
    logic [W-1:0] eq, er;
    int           exp_lat, exp_busy, lat, busy_n, k;
    model(a, b, uns, eq, er);
    exp_lat  = (EarlyOut && is_special(a, b, uns)) ? 1 : W + 2;
    exp_busy = (exp_lat == 1) ? 0 : W + 1;
    start = 1'b1;
    dividend = a;
    divisor = b;
    unsignedSelect = uns;
    k = 0;
    lat = 0;
    busy_n = 0;
    while (lat == 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        unsignedSelect = $urandom_range(0, 1);
      end
      if (ign_at != 0 && k == ign_at) begin
        start = 1'b1;
        dividend = $urandom;
        divisor = $urandom_range(1, 9);
      end
      if (ign_at != 0 && k == ign_at + 1) start = 1'b0;
      if (busy) busy_n++;
      if (k == 5 && !done) check({tag, ".hold"}, quotient, last_q);
      if (done) lat = k;
    end
    check({tag, ".lat"}, W'(lat), W'(exp_lat));
    check({tag, ".busy"}, W'(busy_n), W'(exp_busy));
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    last_q = eq;
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic         uns;
    bit           saw_done;
    int           sel;

    repeat (3) @(negedge clk);
    check("rst.q", quotient, '0);
    check("rst.r", remainder, '0);
    check("rst.busy", W'(busy), '0);
    check("rst.done", W'(done), '0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(32'd100, 32'd7, 1'b0, "s100/7", 0);
    run_op(-32'sd7, 32'd2, 1'b0, "s-7/2", 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, "uFF/1", 0);
    run_op(32'd5, 32'd0, 1'b0, "s5/0", 0);
    run_op(32'd5, 32'd0, 1'b1, "u5/0", 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "sovf", 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "uovf", 0);
    run_op(-32'sd9, 32'd0, 1'b0, "s-9/0", 0);
    run_op(32'd100, 32'd7, 1'b0, "ignore", 10);

    @(negedge clk);
    check("done.pulse", W'(done), '0);
    check("idle.busy", W'(busy), '0);

    // Abort mid-calculation with an asynchronous reset.
    start = 1'b1;
    dividend = 32'd1000;
    divisor = 32'd3;
    unsignedSelect = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("abort.q", quotient, '0);
    check("abort.r", remainder, '0);
    check("abort.busy", W'(busy), '0);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort.nodone", W'(saw_done), '0);
    last_q = '0;
    run_op(32'd9, 32'd3, 1'b0, "post9/3", 0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      a = (($urandom_range(0, 7)) == 0) ? MostNeg : $urandom;
      case (sel)
        0:       b = '0;
        1:       b = '1;
        2:       b = W'($urandom_range(1, 15));
        3:       b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      uns = $urandom_range(0, 1);
      run_op(a, b, uns, $sformatf("rnd%0d", n), 0);
    end

    @(negedge clk);
    check("end.done", W'(done), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/integer_divider.md
INTEGER_DIVIDER -- requirements
Module: integer_divider

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request; accepted only when busy=0.
REQ-004 dividend  input  DATA_WIDTH  rs1 operand; captured on accept.
REQ-005 divisor  input  DATA_WIDTH  rs2 operand; captured on accept.
REQ-006 unsignedSelect  input  1  1 = divu/remu, 0 = div/rem; captured on accept.
REQ-007 quotient  output  DATA_WIDTH  result; feeds result-select input 2.
REQ-008 remainder  output  DATA_WIDTH  result; feeds result-select input 3.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 done  output  1  one-cycle pulse; results valid.

Function
REQ-011 FSM states SHALL be IDLE, CALC, FIXUP and DONE.
REQ-012 IDLE/DONE with start=1 SHALL capture operands, load iteration counter = DATA_WIDTH-1, and go to CALC.
REQ-013 Signed mode SHALL convert operands to magnitudes at capture and record quotient sign (sign(a) XOR sign(b)) and remainder sign (sign(a)).
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle on a (DATA_WIDTH+1)-bit partial remainder, for exactly DATA_WIDTH cycles.
REQ-015 The transition CALC->FIXUP SHALL occur when the counter reaches 0.
REQ-016 FIXUP SHALL negate quotient/remainder per recorded signs, update outputs, and go to DONE.
REQ-017 DONE SHALL assert done for one cycle, then go to IDLE, or to CALC if start=1.
REQ-018 Normal latency SHALL be done high exactly DATA_WIDTH+2 cycles after the accept edge (34 for 32-bit).
REQ-019 busy SHALL be 1 in CALC and FIXUP, and 0 in IDLE and DONE.
REQ-020 start while busy=1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-021 quotient/remainder SHALL hold the last result until the next FIXUP or special-case completion; they do not change during CALC.
REQ-022 Divide by zero SHALL give quotient = all ones and remainder = dividend, in both modes.
REQ-023 Signed overflow (most-negative / -1) SHALL give quotient = most-negative and remainder = 0.
REQ-024 No exception or error flag exists; the REQ-022/023 results are the architectural values.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, quotient=0, remainder=0, busy=0, done=0, counter=0 and sign flags=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-027 The first start after reset release SHALL be accepted normally.

Configuration
REQ-028 Macro DIV_EARLY_OUT_EN SHALL control special-case early completion.
REQ-029 DIV_EARLY_OUT_EN defined: divide-by-zero and signed overflow SHALL be detected at accept, skip CALC/FIXUP, write results, and go straight to DONE (done one cycle after accept).
REQ-030 DIV_EARLY_OUT_EN undefined: every operation SHALL take the REQ-018 latency; the iterative datapath plus FIXUP SHALL still produce the REQ-022/023 values.

Structure
REQ-031 DATA_WIDTH SHALL come from globalVariables.v.
REQ-032 DIV_STATE_WIDTH, the four state encodings and DIV_COUNT_WIDTH (log2 DATA_WIDTH) SHALL be added to globalVariables.v.
REQ-033 The per-iteration shift/compare/subtract SHALL be a combinational sub-module divider_step (inputs: partial remainder, dividend bit, divisor; outputs: next remainder, quotient bit), instantiated once.
REQ-034 The counter, FSM and sign fix-up SHALL live in integer_divider.

Verification
REQ-035 Signed 100 / 7 -> quotient=14, remainder=2; done exactly 34 cycles after accept; busy high for 33 cycles.
REQ-036 Signed -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-037 5 / 0 (both modes) -> quotient=0xFFFFFFFF, remainder=5; latency 1 with DIV_EARLY_OUT_EN, 34 without.
REQ-038 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned same operands -> quotient=0, remainder=0x80000000.
REQ-039 Second start pulsed at cycle 10 of an operation -> ignored; the first result is unchanged; a start issued in the DONE cycle is accepted back-to-back.
REQ-040 reset_n pulsed low at cycle 15 of CALC -> outputs 0, no done pulse; a following 9 / 3 returns 3 r 0.
